// File: rtl/hex_bcd_formatter_if.sv
// Request/result bundle between a binary producer and the BCD display formatter.
// Latency: n/a (wires only). Backpressure: none; requests during a conversion are buffered by the formatter.
interface hex_bcd_formatter_if #(
    parameter int BIN_W = 27
) ();
    logic [BIN_W-1:0] value_in;
    logic             valid_in;
    logic [31:0]      bcd_out;
    logic             busy_out;
    logic             done_out;
    logic             dropped_out;

    modport master (
        output value_in,
        output valid_in,
        input  bcd_out,
        input  busy_out,
        input  done_out,
        input  dropped_out
    );

    modport slave (
        input  value_in,
        input  valid_in,
        output bcd_out,
        output busy_out,
        output done_out,
        output dropped_out
    );
endinterface

// File: rtl/hex_bcd_formatter.sv
// Iterative double-dabble binary-to-8-digit-BCD converter holding its result for the display driver.
// Latency: BIN_W+1 cycles from capture to bcd_out/done_out. Backpressure: none; one-deep pending slot, newest value wins.
module hex_bcd_formatter #(
    parameter int          BIN_W   = 27,
    parameter int unsigned MAX_VAL = 99_999_999
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    hex_bcd_formatter_if.slave    bus
);
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_sr_q, bin_sr_d;
    logic [31:0]      bcd_sr_q, bcd_sr_d;
    logic             ovf_q, ovf_d;
    logic [BIN_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic [31:0]      bcd_out_q, bcd_out_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;

    logic [31:0]      bcd_adj;
    logic             load;
    logic [BIN_W-1:0] load_val;

    // Per-nibble add-3 correction; nibbles are independent, no carry between digits.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 8; i++) begin
            if (bcd_sr_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_sr_d  = bin_sr_q;
        bcd_sr_d  = bcd_sr_q;
        ovf_d     = ovf_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        bcd_out_d = bcd_out_q;
        done_d    = 1'b0;
        drop_d    = 1'b0;
        load      = 1'b0;
        load_val  = bus.value_in;

        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    load = 1'b1;
                end
            end

            SHIFT: begin
                bcd_sr_d = {bcd_adj[30:0], bin_sr_q[BIN_W-1]};
                bin_sr_d = {bin_sr_q[BIN_W-2:0], 1'b0};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
                if (bus.valid_in) begin
                    pend_d   = bus.value_in;
                    pend_v_d = 1'b1;
                    drop_d   = pend_v_q;
                end
            end

            DONE: begin
                bcd_out_d = ovf_q ? 32'hFFFF_FFFF : bcd_sr_q;
                done_d    = 1'b1;
                // A fresh request outranks the buffered one, which is then lost.
                if (bus.valid_in) begin
                    load     = 1'b1;
                    pend_v_d = 1'b0;
                    drop_d   = pend_v_q;
                end else if (pend_v_q) begin
                    load     = 1'b1;
                    load_val = pend_q;
                    pend_v_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            bin_sr_d = load_val;
            bcd_sr_d = '0;
            ovf_d    = (32'(load_val) > MAX_VAL);
            cnt_d    = '0;
            state_d  = SHIFT;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bin_sr_q  <= '0;
            bcd_sr_q  <= '0;
            ovf_q     <= 1'b0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            bcd_out_q <= '0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_sr_q  <= bin_sr_d;
            bcd_sr_q  <= bcd_sr_d;
            ovf_q     <= ovf_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            bcd_out_q <= bcd_out_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.bcd_out     = bcd_out_q;
    assign bus.busy_out    = (state_q != IDLE);
    assign bus.done_out    = done_q;
    assign bus.dropped_out = drop_q;

endmodule

// File: tb/tb_hex_bcd_formatter.sv
// Scoreboard bench: a transaction-level reference queues expected results, drops and busy state;
// a separate monitor compares every cycle after the clock edge.
module tb_hex_bcd_formatter;
    localparam int          BIN_W   = 27;
    localparam int unsigned MAX_VAL = 99_999_999;
    localparam int          LAT     = BIN_W + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hex_bcd_formatter_if #(.BIN_W(BIN_W)) bus ();

    hex_bcd_formatter #(.BIN_W(BIN_W), .MAX_VAL(MAX_VAL)) dut (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bcd;
        int          edge_n;
    } exp_t;

    exp_t exp_q[$];
    int   drop_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    bit               m_active    = 1'b0;
    bit               m_pend_v    = 1'b0;
    bit               m_busy      = 1'b0;
    int               m_done_edge = 0;
    logic [BIN_W-1:0] m_pend      = '0;
    logic [31:0]      disp_exp    = '0;

    // Decimal digits by plain division; anything above MAX_VAL shows all F.
    function automatic logic [31:0] ref_bcd(input logic [BIN_W-1:0] v);
        int unsigned x;
        logic [31:0] r;
        x = 32'(v);
        if (x > MAX_VAL) return 32'hFFFF_FFFF;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic start_conv(input int e, input logic [BIN_W-1:0] v);
        exp_t x;
        m_active    = 1'b1;
        m_done_edge = e + LAT;
        x.bcd       = ref_bcd(v);
        x.edge_n    = e + LAT;
        exp_q.push_back(x);
    endtask

    // Reference: what the sampled inputs at clock edge e do to the conversion schedule.
    task automatic model_step(input int e, input bit rst, input bit v, input logic [BIN_W-1:0] val);
        if (!rst) begin
            m_active = 1'b0;
            m_pend_v = 1'b0;
            exp_q.delete();
            drop_q.delete();
        end else if (m_active && e == m_done_edge) begin
            if (v) begin
                if (m_pend_v) drop_q.push_back(e);
                m_pend_v = 1'b0;
                start_conv(e, val);
            end else if (m_pend_v) begin
                m_pend_v = 1'b0;
                start_conv(e, m_pend);
            end else begin
                m_active = 1'b0;
            end
        end else if (m_active) begin
            if (v) begin
                if (m_pend_v) drop_q.push_back(e);
                m_pend   = val;
                m_pend_v = 1'b1;
            end
        end else if (v) begin
            start_conv(e, val);
        end
        m_busy = m_active;
    endtask

    task automatic tick(input bit v, input logic [BIN_W-1:0] val, input bit rst);
        @(negedge clk);
        rst_n        = rst;
        bus.valid_in = v;
        bus.value_in = val;
        model_step(cyc + 1, rst, v, val);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, BIN_W'($urandom), 1'b1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: runs just after each edge, independent of the stimulus thread.
    always @(posedge clk) begin
        exp_t x;
        bit   want_drop;
        #1;
        if (!rst_n) begin
            disp_exp = '0;
            chk("rst_bcd", bus.bcd_out, 32'h0);
            chk("rst_busy", 32'(bus.busy_out), 32'h0);
            chk("rst_done", 32'(bus.done_out), 32'h0);
            chk("rst_dropped", 32'(bus.dropped_out), 32'h0);
        end else begin
            if (bus.done_out) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: bcd %h, no result expected (edge %0d)", bus.bcd_out, cyc);
                end else begin
                    x = exp_q.pop_front();
                    chk("result", bus.bcd_out, x.bcd);
                    chk("done_edge", 32'(cyc), 32'(x.edge_n));
                    disp_exp = x.bcd;
                end
            end else if (exp_q.size() > 0 && exp_q[0].edge_n <= cyc) begin
                x = exp_q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL missing_done: expected %h by edge %0d (edge %0d)", x.bcd, x.edge_n, cyc);
            end
            chk("bcd_hold", bus.bcd_out, disp_exp);
            want_drop = 1'b0;
            if (drop_q.size() > 0 && drop_q[0] == cyc) begin
                want_drop = 1'b1;
                void'(drop_q.pop_front());
            end
            chk("dropped", 32'(bus.dropped_out), 32'(want_drop));
            chk("busy", 32'(bus.busy_out), 32'(m_busy));
        end
    end

    initial begin
        logic [BIN_W-1:0] v;
        bus.valid_in = 1'b0;
        bus.value_in = '0;
        rst_n        = 1'b0;

        repeat (3) tick(1'b0, '0, 1'b0);

        tick(1'b1, BIN_W'(12_345_678), 1'b1);
        idle(LAT + 4);

        tick(1'b1, BIN_W'(0), 1'b1);           idle(LAT + 2);
        tick(1'b1, BIN_W'(99_999_999), 1'b1);  idle(LAT + 2);
        tick(1'b1, BIN_W'(100_000_000), 1'b1); idle(LAT + 2);
        tick(1'b1, {BIN_W{1'b1}}, 1'b1);       idle(LAT + 2);

        // Two requests inside one conversion: the second overwrites the first pending one.
        tick(1'b1, BIN_W'(42), 1'b1);
        idle(4);
        tick(1'b1, BIN_W'(7), 1'b1);
        idle(4);
        tick(1'b1, BIN_W'(900), 1'b1);
        idle(2 * LAT + 4);

        // Request landing exactly on the DONE decision edge.
        tick(1'b1, BIN_W'(1), 1'b1);
        idle(LAT - 1);
        tick(1'b1, BIN_W'(5), 1'b1);
        idle(LAT + 4);

        // Reset mid-conversion with a value pending.
        tick(1'b0, '0, 1'b0);
        tick(1'b1, BIN_W'(87_654_321), 1'b1);
        idle(13);
        tick(1'b1, BIN_W'(555), 1'b1);
        tick(1'b0, '0, 1'b0);
        idle(2 * LAT + 4);
        @(negedge clk);
        chk("abort_bcd", bus.bcd_out, 32'h0);

        for (int i = 0; i < 10000; i++) begin
            idle($urandom_range(0, 9));
            case ($urandom_range(0, 7))
                0: begin
                    case ($urandom_range(0, 3))
                        0:       v = '0;
                        1:       v = BIN_W'(MAX_VAL);
                        2:       v = BIN_W'(MAX_VAL + 1);
                        default: v = {BIN_W{1'b1}};
                    endcase
                end
                1:       v = BIN_W'($urandom_range(MAX_VAL + 1, (1 << BIN_W) - 1));
                default: v = BIN_W'($urandom_range(0, MAX_VAL));
            endcase
            tick(1'b1, v, 1'b1);
        end
        idle(2 * LAT + 8);

        chk("results_left", 32'(exp_q.size()), 32'h0);
        chk("drops_left", 32'(drop_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
